// File: rtl/dmem_mmio.sv
// Data-side responder for the RV32 core: byte-lane RAM plus an MMIO page holding
// a cycle counter, a timer compare with a sticky interrupt, and a console TX FIFO.
module dmem_mmio #(
   parameter int    DMEM_WORDS = 1024,
   parameter int    FIFO_DEPTH = 8,
   parameter string INIT_FILE  = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] daddr,
   input  logic [31:0] dwdata,
   input  logic [3:0]  dwe,
   output logic [31:0] drdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        timer_irq
);

   localparam int AW = $clog2(DMEM_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   logic [31:0]   mem [DMEM_WORDS];
   logic [7:0]    fifo [FIFO_DEPTH];
   logic [31:0]   cycle;
   logic [31:0]   mtimecmp;
   logic          pending;
   logic          overflow;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [7:0]    count8;

   logic [AW-1:0] ram_idx;
   logic [1:0]    reg_sel;
   logic          mmio_sel;
   logic          any_we;
   logic [3:0]    ram_we;
   logic [3:0]    cmp_we;
   logic          status_we;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic          accept;
   logic          timer_hit;
   logic          unused_addr;

   assign ram_idx     = daddr[AW+1:2];
   assign reg_sel     = daddr[3:2];
   assign mmio_sel    = daddr[31];
   assign any_we      = |dwe;
   assign unused_addr = ^{daddr[30:AW+2], daddr[1:0]};

   assign ram_we    = mmio_sel ? 4'b0000 : dwe;
   assign cmp_we    = (mmio_sel && reg_sel == 2'd1) ? dwe : 4'b0000;
   assign status_we = any_we && mmio_sel && reg_sel == 2'd2 && dwe[0];
   assign push      = any_we && mmio_sel && reg_sel == 2'd3 && dwe[0];

   assign empty  = (count == '0);
   assign full   = (count == CNT_FULL);
   assign pop    = !empty && tx_ready;
   // A full FIFO still takes a push when the head leaves on the same edge.
   assign accept = push && (!full || pop);

   assign timer_hit = (cycle == mtimecmp) && (mtimecmp != 32'h0);

   assign tx_valid  = !empty;
   assign tx_data   = fifo[rd_ptr];
   assign timer_irq = pending;
   assign count8    = 8'(count);

   always_ff @(posedge clk) begin
      for (int n = 0; n < 4; n++) begin
         if (ram_we[n]) mem[ram_idx][8*n +: 8] <= dwdata[8*n +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (accept) fifo[wr_ptr] <= dwdata[7:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle    <= 32'h0;
         mtimecmp <= 32'h0;
         pending  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         cycle <= cycle + 32'h1;
         for (int n = 0; n < 4; n++) begin
            if (cmp_we[n]) mtimecmp[8*n +: 8] <= dwdata[8*n +: 8];
         end
         // Set wins over a same-cycle write-one-to-clear.
         if (timer_hit)
            pending <= 1'b1;
         else if (status_we && dwdata[2])
            pending <= 1'b0;
         if (push && full && !pop)
            overflow <= 1'b1;
         else if (status_we && dwdata[3])
            overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
         case ({accept, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      drdata = 32'h0;
      if (!mmio_sel) begin
         drdata = mem[ram_idx];
      end else begin
         case (reg_sel)
            2'd0:    drdata = cycle;
            2'd1:    drdata = mtimecmp;
            2'd2:    drdata = {16'h0, count8, 4'h0, overflow, pending, full, empty};
            default: drdata = 32'h0;
         endcase
      end
   end

endmodule
